// File: rtl/l1_nn_pkg.sv
// Shared definitions for the L1 neuron blocks: default sizes, FSM state
// encodings and the signed saturation helper used by forward and backward paths.
package l1_nn_pkg;

  localparam int N_DEF     = 4;
  localparam int WIDTH_DEF = 8;

  // FSM encodings kept as plain constants so older blocks can compare against them
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Clamp a signed value to the range of a signed word of the given width
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                      input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/l1_neuron_bwd_sat.sv
// Parameterised signed clamp from a wide accumulator down to the element width.
module l1_sat
  import l1_nn_pkg::*;
#(
  parameter int ACC_WIDTH = 2 * WIDTH_DEF + 1,
  parameter int WIDTH     = WIDTH_DEF
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic signed [WIDTH-1:0]     sat
);

  assign sat = WIDTH'(sat_to_width(64'(acc), WIDTH));

endmodule

// File: rtl/l1_neuron_bwd.sv
// Backward pass of the L1 neuron: walks the N elements one per cycle, producing
// input gradients, SGD-updated weights and the updated bias behind a
// valid/ready handshake on each side.
module l1_neuron_bwd
  import l1_nn_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int LR_SHIFT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   x,
  input  logic [N*WIDTH-1:0]   w,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     dy,
  input  logic                 act,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WIDTH-1:0]   dx,
  output logic [N*WIDTH-1:0]   w_new,
  output logic [WIDTH-1:0]     b_new,
  output logic                 busy
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  state_t                   state;
  logic [IDX_W-1:0]         index;
  logic [N*WIDTH-1:0]       x_r;
  logic [N*WIDTH-1:0]       w_r;
  logic signed [WIDTH-1:0]  b_r;
  logic signed [WIDTH-1:0]  g_r;

  logic signed [WIDTH-1:0]     x_i;
  logic signed [WIDTH-1:0]     w_i;
  logic signed [2*WIDTH-1:0]   p;
  logic signed [2*WIDTH-1:0]   q;
  logic signed [2*WIDTH-1:0]   q_sh;
  logic signed [2*WIDTH:0]     w_acc;
  logic signed [WIDTH-1:0]     g_sh;
  logic signed [WIDTH:0]       b_acc;
  logic signed [WIDTH-1:0]     dx_i;
  logic signed [WIDTH-1:0]     w_new_i;
  logic signed [WIDTH-1:0]     b_new_i;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  // Current element pulled from the captured vectors
  assign x_i = x_r[index*WIDTH +: WIDTH];
  assign w_i = w_r[index*WIDTH +: WIDTH];

  // Gradient products are full width so the clamp sees the true value
  assign p     = g_r * w_i;
  assign q     = g_r * x_i;
  assign q_sh  = q >>> LR_SHIFT;
  assign w_acc = (2*WIDTH+1)'(w_i) - (2*WIDTH+1)'(q_sh);
  assign g_sh  = g_r >>> LR_SHIFT;
  assign b_acc = (WIDTH+1)'(b_r) - (WIDTH+1)'(g_sh);

  l1_sat #(.ACC_WIDTH(2*WIDTH), .WIDTH(WIDTH)) u_sat_dx (
    .acc (p),
    .sat (dx_i)
  );

  l1_sat #(.ACC_WIDTH(2*WIDTH+1), .WIDTH(WIDTH)) u_sat_w (
    .acc (w_acc),
    .sat (w_new_i)
  );

  l1_sat #(.ACC_WIDTH(WIDTH+1), .WIDTH(WIDTH)) u_sat_b (
    .acc (b_acc),
    .sat (b_new_i)
  );

  // Handshake FSM: capture in IDLE, one element per cycle in CALC, hold in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      index <= '0;
      x_r   <= '0;
      w_r   <= '0;
      b_r   <= '0;
      g_r   <= '0;
      dx    <= '0;
      w_new <= '0;
      b_new <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x_r   <= x;
            w_r   <= w;
            b_r   <= b;
            g_r   <= act ? dy : '0;
            index <= '0;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          dx[index*WIDTH +: WIDTH]    <= dx_i;
          w_new[index*WIDTH +: WIDTH] <= w_new_i;
          if (index == '0) begin
            b_new <= b_new_i;
          end
          if (index == IDX_W'(N - 1)) begin
            index <= '0;
            state <= ST_DONE;
          end else begin
            index <= index + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_neuron_bwd.sv
// Directed self-checking bench for the L1 neuron backward pass.
module tb_l1_neuron_bwd;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [31:0] w;
  logic [7:0]  b;
  logic [7:0]  dy;
  logic        act;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dx;
  logic [31:0] w_new;
  logic [7:0]  b_new;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int lat;
  int seen;
  int last_cyc;

  l1_neuron_bwd dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .w         (w),
    .b         (b),
    .dy        (dy),
    .act       (act),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dx        (dx),
    .w_new     (w_new),
    .b_new     (b_new),
    .busy      (busy)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pack4(input int e0, input int e1, input int e2, input int e3);
    return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a request at the falling edge and let the next rising edge accept it
  task automatic applyStimulus(input logic [31:0] xv, input logic [31:0] wv,
                               input int bv, input int dyv, input logic actv,
                               input logic hold_valid);
    @(negedge clk);
    x        = xv;
    w        = wv;
    b        = 8'(bv);
    dy       = 8'(dyv);
    act      = actv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_valid) in_valid = 1'b0;
  endtask

  // Count rising edges from the accept edge until out_valid shows up
  task automatic waitResult(output int l);
    l = 21;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x = '0; w = '0; b = '0; dy = '0; act = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_dx", dx, 0);
    checkOutput("rst_w_new", w_new, 0);
    checkOutput("rst_b_new", b_new, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic update with saturating gradients
    applyStimulus(pack4(1, 2, 3, 4), pack4(10, -20, 30, -40), 5, 16, 1'b1, 1'b0);
    checkOutput("t1_busy", busy, 1);
    waitResult(lat);
    checkOutput("t1_latency", lat, 4);
    checkOutput("t1_dx", dx, pack4(127, -128, 127, -128));
    checkOutput("t1_w_new", w_new, pack4(9, -22, 27, -44));
    checkOutput("t1_b_new", b_new, 8'(4));
    consume();
    checkOutput("t1_idle", in_ready, 1);

    // Inactive ReLU leaves parameters untouched
    applyStimulus(pack4(1, 2, 3, 4), pack4(10, -20, 30, -40), 5, 16, 1'b0, 1'b0);
    waitResult(lat);
    checkOutput("t2_latency", lat, 4);
    checkOutput("t2_dx", dx, 0);
    checkOutput("t2_w_new", w_new, pack4(10, -20, 30, -40));
    checkOutput("t2_b_new", b_new, 8'(5));
    consume();

    // Negative gradient, floor shift and saturation at both rails
    applyStimulus(pack4(1, 1, 1, 1), pack4(127, -128, 0, 5), 127, -1, 1'b1, 1'b0);
    waitResult(lat);
    checkOutput("t3_latency", lat, 4);
    checkOutput("t3_dx", dx, pack4(-127, 127, 0, -5));
    checkOutput("t3_w_new", w_new, pack4(127, -127, 1, 6));
    checkOutput("t3_b_new", b_new, 8'(127));
    consume();

    // Backpressure in DONE with a pending request on the input
    applyStimulus(pack4(1, 2, 3, 4), pack4(10, -20, 30, -40), 5, 16, 1'b1, 1'b0);
    waitResult(lat);
    checkOutput("t4_latency", lat, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      x        = pack4(i, i + 7, -i, 3 * i);
      dy       = 8'(i + 40);
      act      = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("t4_hold_valid", out_valid, 1);
      checkOutput("t4_hold_in_ready", in_ready, 0);
      checkOutput("t4_hold_dx", dx, pack4(127, -128, 127, -128));
      checkOutput("t4_hold_w_new", w_new, pack4(9, -22, 27, -44));
      checkOutput("t4_hold_b_new", b_new, 8'(4));
    end
    @(negedge clk);
    x  = pack4(1, 1, 1, 1);
    w  = pack4(127, -128, 0, 5);
    b  = 8'(127);
    dy = 8'(-1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("t4_release_in_ready", in_ready, 1);
    checkOutput("t4_release_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("t4_accept_busy", busy, 1);
    waitResult(lat);
    checkOutput("t4_new_latency", lat, 4);
    checkOutput("t4_new_dx", dx, pack4(-127, 127, 0, -5));
    checkOutput("t4_new_w_new", w_new, pack4(127, -127, 1, 6));
    checkOutput("t4_new_b_new", b_new, 8'(127));
    consume();

    // Reset while element 2 is next in line
    applyStimulus(pack4(1, 2, 3, 4), pack4(10, -20, 30, -40), 5, 16, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_out_valid", out_valid, 0);
    checkOutput("t5_rst_in_ready", in_ready, 1);
    checkOutput("t5_rst_dx", dx, 0);
    checkOutput("t5_rst_w_new", w_new, 0);
    checkOutput("t5_rst_b_new", b_new, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(pack4(1, 2, 3, 4), pack4(10, -20, 30, -40), 5, 16, 1'b1, 1'b0);
    waitResult(lat);
    checkOutput("t5_latency", lat, 4);
    checkOutput("t5_dx", dx, pack4(127, -128, 127, -128));
    checkOutput("t5_w_new", w_new, pack4(9, -22, 27, -44));
    checkOutput("t5_b_new", b_new, 8'(4));
    consume();

    // Back-to-back requests with the consumer always ready
    @(negedge clk);
    out_ready = 1'b1;
    applyStimulus(pack4(1, 2, 3, 4), pack4(10, -20, 30, -40), 5, 16, 1'b1, 1'b1);
    seen     = 0;
    last_cyc = 0;
    for (int cyc = 1; cyc <= 40 && seen < 3; cyc++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (seen == 0) begin
          checkOutput("t6_r0_cycle", cyc, 4);
          checkOutput("t6_r0_dx", dx, pack4(127, -128, 127, -128));
          checkOutput("t6_r0_w_new", w_new, pack4(9, -22, 27, -44));
          checkOutput("t6_r0_b_new", b_new, 8'(4));
          act = 1'b0;
        end else if (seen == 1) begin
          checkOutput("t6_r1_spacing", cyc - last_cyc, 6);
          checkOutput("t6_r1_dx", dx, 0);
          checkOutput("t6_r1_w_new", w_new, pack4(10, -20, 30, -40));
          checkOutput("t6_r1_b_new", b_new, 8'(5));
          x   = pack4(1, 1, 1, 1);
          w   = pack4(127, -128, 0, 5);
          b   = 8'(127);
          dy  = 8'(-1);
          act = 1'b1;
        end else begin
          checkOutput("t6_r2_spacing", cyc - last_cyc, 6);
          checkOutput("t6_r2_dx", dx, pack4(-127, 127, 0, -5));
          checkOutput("t6_r2_w_new", w_new, pack4(127, -127, 1, 6));
          checkOutput("t6_r2_b_new", b_new, 8'(127));
          in_valid = 1'b0;
        end
        last_cyc = cyc;
        seen++;
      end
    end
    checkOutput("t6_result_count", seen, 3);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
